// File: rtl/active_list_commit_pkg.sv
// Shared definitions for the active list (in-order retirement buffer).
//   - Default bus widths for index, architectural and physical registers.
//   - ACTIVE_LIST_DEPTH: number of entries at the default index width.
//   - Entry field layout helpers. A stored entry is packed as
//     {has_dest, vaddr, paddr, old_paddr} with old_paddr at bit 0.
package active_list_commit_pkg;

  localparam int unsigned FREE_LIST_BUS     = 3;
  localparam int unsigned VREG_BUS          = 5;
  localparam int unsigned PREG_BUS          = 6;
  localparam int unsigned ACTIVE_LIST_DEPTH = 2 ** FREE_LIST_BUS;

  localparam int unsigned AL_OLD_PADDR_OFF  = 0;

  function automatic int unsigned al_paddr_off(input int unsigned preg_w);
    return AL_OLD_PADDR_OFF + preg_w;
  endfunction

  function automatic int unsigned al_vaddr_off(input int unsigned preg_w);
    return AL_OLD_PADDR_OFF + 2 * preg_w;
  endfunction

  function automatic int unsigned al_has_dest_off(input int unsigned vreg_w,
                                                  input int unsigned preg_w);
    return al_vaddr_off(preg_w) + vreg_w;
  endfunction

  function automatic int unsigned al_entry_width(input int unsigned vreg_w,
                                                 input int unsigned preg_w);
    return al_has_dest_off(vreg_w, preg_w) + 1;
  endfunction

endpackage

// File: rtl/active_list_commit_if.sv
// Allocation / writeback / retirement bus of the active list.
//   slave  : the active list itself (accepts alloc and wb, drives commit/free)
//   master : the pipeline side (rename, writeback, architectural map, free list)
interface active_list_commit_if
  import active_list_commit_pkg::*;
#(
  parameter int unsigned FREE_LIST_WIDTH = FREE_LIST_BUS,
  parameter int unsigned VREG_WIDTH      = VREG_BUS,
  parameter int unsigned PREG_WIDTH      = PREG_BUS
);

  // Rename-side allocation
  logic                       alloc_valid;
  logic                       alloc_has_dest;
  logic [VREG_WIDTH-1:0]      alloc_virtual_addr;
  logic [PREG_WIDTH-1:0]      alloc_physical_addr;
  logic [PREG_WIDTH-1:0]      alloc_old_physical_addr;
  logic                       alloc_ready;
  logic [FREE_LIST_WIDTH-1:0] alloc_index;

  // Writeback completion
  logic                       wb_done;
  logic [FREE_LIST_WIDTH-1:0] wb_index;

  // Retirement
  logic                       commit_valid;
  logic [VREG_WIDTH-1:0]      commit_virtual_addr;
  logic [PREG_WIDTH-1:0]      commit_physical_addr;
  logic                       free_valid;
  logic [PREG_WIDTH-1:0]      free_physical_addr;

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_virtual_addr,
           alloc_physical_addr, alloc_old_physical_addr,
           wb_done, wb_index,
    output alloc_ready, alloc_index,
           commit_valid, commit_virtual_addr, commit_physical_addr,
           free_valid, free_physical_addr
  );

  modport master (
    output alloc_valid, alloc_has_dest, alloc_virtual_addr,
           alloc_physical_addr, alloc_old_physical_addr,
           wb_done, wb_index,
    input  alloc_ready, alloc_index,
           commit_valid, commit_virtual_addr, commit_physical_addr,
           free_valid, free_physical_addr
  );

endinterface

// File: rtl/active_list_commit_circ_ptr.sv
// circ_ptr: circular pointer register with an extra wrap bit above the index.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   inc       : advance by one, wrapping through the wrap bit
//   load      : overwrite with load_val (takes priority over inc)
//   load_val  : value for load
//   ptr_q     : registered pointer {wrap, index}
module circ_ptr #(
  parameter int unsigned IDX_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [IDX_WIDTH:0] load_val,
  output logic [IDX_WIDTH:0] ptr_q
);

  logic [IDX_WIDTH:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + {{IDX_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/active_list_commit.sv
// active_list_commit: in-order retirement buffer for the renamed pipeline.
// Rename allocates at the tail and receives the entry index; writeback marks
// entries done by index; done entries retire strictly from the head, one per
// cycle, returning the superseded physical register to the free list.
//   clk, rst      : clock, synchronous active-high reset
//   global_flush  : discard all entries (pointers kept, tail pulled to head)
//   commit_stall  : hold retirement
//   al (slave)    : alloc_*, wb_*, commit_*, free_* bus
//   count, empty  : occupancy status
module active_list_commit
  import active_list_commit_pkg::*;
#(
  parameter int unsigned FREE_LIST_WIDTH = FREE_LIST_BUS,
  parameter int unsigned VREG_WIDTH      = VREG_BUS,
  parameter int unsigned PREG_WIDTH      = PREG_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     global_flush,
  input  logic                     commit_stall,
  active_list_commit_if.slave      al,
  output logic [FREE_LIST_WIDTH:0] count,
  output logic                     empty
);

  localparam int unsigned DEPTH        = 2 ** FREE_LIST_WIDTH;
  localparam int unsigned ENTRY_W      = al_entry_width(VREG_WIDTH, PREG_WIDTH);
  localparam int unsigned OLD_OFF      = AL_OLD_PADDR_OFF;
  localparam int unsigned PADDR_OFF    = al_paddr_off(PREG_WIDTH);
  localparam int unsigned VADDR_OFF    = al_vaddr_off(PREG_WIDTH);
  localparam int unsigned HAS_DEST_OFF = al_has_dest_off(VREG_WIDTH, PREG_WIDTH);

  logic [FREE_LIST_WIDTH:0]   head_q, tail_q;
  logic [FREE_LIST_WIDTH-1:0] head_idx, tail_idx;
  logic                       full;
  logic                       alloc_fire, wb_fire, retire;

  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [DEPTH-1:0]           done_q, done_d;
  logic [ENTRY_W-1:0]         entry_q [DEPTH];
  logic [ENTRY_W-1:0]         entry_d [DEPTH];
  logic [ENTRY_W-1:0]         head_entry, alloc_entry;

  logic                       commit_valid_q, commit_valid_d;
  logic [VREG_WIDTH-1:0]      commit_vaddr_q, commit_vaddr_d;
  logic [PREG_WIDTH-1:0]      commit_paddr_q, commit_paddr_d;
  logic                       free_valid_q, free_valid_d;
  logic [PREG_WIDTH-1:0]      free_paddr_q, free_paddr_d;

  // Pointers: head advances on retire; tail advances on alloc and is pulled
  // back onto head by a flush so the pointer values survive recovery.
  circ_ptr #(.IDX_WIDTH(FREE_LIST_WIDTH)) u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (retire),
    .load     (1'b0),
    .load_val ('0),
    .ptr_q    (head_q)
  );

  circ_ptr #(.IDX_WIDTH(FREE_LIST_WIDTH)) u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (alloc_fire),
    .load     (global_flush),
    .load_val (head_q),
    .ptr_q    (tail_q)
  );

  // Status and handshake decisions, all from registered state.
  always_comb begin
    head_idx   = head_q[FREE_LIST_WIDTH-1:0];
    tail_idx   = tail_q[FREE_LIST_WIDTH-1:0];
    empty      = (head_q == tail_q);
    full       = (head_idx == tail_idx) &&
                 (head_q[FREE_LIST_WIDTH] != tail_q[FREE_LIST_WIDTH]);
    count      = tail_q - head_q;
    head_entry = entry_q[head_idx];
    alloc_fire = al.alloc_valid && !full && !global_flush;
    wb_fire    = al.wb_done && valid_q[al.wb_index] && !global_flush;
    retire     = valid_q[head_idx] && done_q[head_idx] &&
                 !commit_stall && !global_flush;
  end

  always_comb begin
    alloc_entry                             = '0;
    alloc_entry[HAS_DEST_OFF]               = al.alloc_has_dest;
    alloc_entry[VADDR_OFF +: VREG_WIDTH]    = al.alloc_virtual_addr;
    alloc_entry[PADDR_OFF +: PREG_WIDTH]    = al.alloc_physical_addr;
    alloc_entry[OLD_OFF +: PREG_WIDTH]      = al.alloc_old_physical_addr;
  end

  // Entry state update. Writeback is applied before the retire clear so a
  // redundant wb_done to a retiring head cannot leave a stale done bit.
  // Alloc never targets a valid slot (tail slot is free unless full).
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    entry_d = entry_q;
    if (global_flush) begin
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (wb_fire) begin
        done_d[al.wb_index] = 1'b1;
      end
      if (retire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        entry_d[tail_idx] = alloc_entry;
      end
    end
  end

  // Registered retire outputs; addresses hold when nothing retires.
  always_comb begin
    commit_valid_d = retire;
    free_valid_d   = retire && head_entry[HAS_DEST_OFF];
    commit_vaddr_d = commit_vaddr_q;
    commit_paddr_d = commit_paddr_q;
    free_paddr_d   = free_paddr_q;
    if (retire) begin
      commit_vaddr_d = head_entry[VADDR_OFF +: VREG_WIDTH];
      commit_paddr_d = head_entry[PADDR_OFF +: PREG_WIDTH];
      free_paddr_d   = head_entry[OLD_OFF +: PREG_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_vaddr_q <= '0;
      commit_paddr_q <= '0;
      free_valid_q   <= 1'b0;
      free_paddr_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_vaddr_q <= commit_vaddr_d;
      commit_paddr_q <= commit_paddr_d;
      free_valid_q   <= free_valid_d;
      free_paddr_q   <= free_paddr_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign al.alloc_ready          = !full;
  assign al.alloc_index          = tail_idx;
  assign al.commit_valid         = commit_valid_q;
  assign al.commit_virtual_addr  = commit_vaddr_q;
  assign al.commit_physical_addr = commit_paddr_q;
  assign al.free_valid           = free_valid_q;
  assign al.free_physical_addr   = free_paddr_q;

endmodule

// File: tb/tb_active_list_commit.sv
// Bench for active_list_commit: directed scenarios plus a randomized run,
// checked against a program-order queue model of the active list.
module tb_active_list_commit;
  import active_list_commit_pkg::*;

  localparam int unsigned FLW   = FREE_LIST_BUS;
  localparam int unsigned VW    = VREG_BUS;
  localparam int unsigned PW    = PREG_BUS;
  localparam int          DEPTH = ACTIVE_LIST_DEPTH;

  logic clk = 1'b0;
  logic rst, global_flush, commit_stall;
  logic alloc_valid, alloc_has_dest, wb_done;
  logic [VW-1:0]  alloc_vaddr;
  logic [PW-1:0]  alloc_paddr, alloc_old;
  logic [FLW-1:0] wb_index;
  logic [FLW:0]   count;
  logic           empty;
  logic           alloc_ready, commit_valid, free_valid;
  logic [FLW-1:0] alloc_index;
  logic [VW-1:0]  commit_vaddr;
  logic [PW-1:0]  commit_paddr, free_paddr;

  active_list_commit_if #(.FREE_LIST_WIDTH(FLW), .VREG_WIDTH(VW), .PREG_WIDTH(PW)) al_if ();

  assign al_if.alloc_valid             = alloc_valid;
  assign al_if.alloc_has_dest          = alloc_has_dest;
  assign al_if.alloc_virtual_addr      = alloc_vaddr;
  assign al_if.alloc_physical_addr     = alloc_paddr;
  assign al_if.alloc_old_physical_addr = alloc_old;
  assign al_if.wb_done                 = wb_done;
  assign al_if.wb_index                = wb_index;
  assign alloc_ready  = al_if.alloc_ready;
  assign alloc_index  = al_if.alloc_index;
  assign commit_valid = al_if.commit_valid;
  assign commit_vaddr = al_if.commit_virtual_addr;
  assign commit_paddr = al_if.commit_physical_addr;
  assign free_valid   = al_if.free_valid;
  assign free_paddr   = al_if.free_physical_addr;

  active_list_commit #(.FREE_LIST_WIDTH(FLW), .VREG_WIDTH(VW), .PREG_WIDTH(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .global_flush (global_flush),
    .commit_stall (commit_stall),
    .al           (al_if),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  // Reference model: entries in program order; the head index is m_head mod DEPTH.
  typedef struct {
    int v;
    int p;
    int old;
    bit hd;
    bit done;
  } ent_t;

  ent_t mq[$];
  int   m_head;
  bit   e_cv, e_fv;
  int   e_cva, e_cpa, e_fpa;
  int   vectors = 0;
  int   errs    = 0;

  task automatic idle();
    alloc_valid = 1'b0; wb_done = 1'b0; global_flush = 1'b0; commit_stall = 1'b0;
  endtask

  task automatic set_alloc(input bit hd, input int v, input int p, input int old);
    alloc_valid = 1'b1; alloc_has_dest = hd;
    alloc_vaddr = VW'(v); alloc_paddr = PW'(p); alloc_old = PW'(old);
  endtask

  task automatic set_wb(input int idx);
    wb_done = 1'b1; wb_index = FLW'(idx);
  endtask

  // Advance the model by one clock using the inputs now applied, then step
  // the DUT and settle 1 time unit past the edge.
  task automatic cycle();
    ent_t r;
    bit   ret, can_alloc;
    int   k;
    if (rst) begin
      mq.delete(); m_head = 0;
      e_cv = 0; e_fv = 0; e_cva = 0; e_cpa = 0; e_fpa = 0;
    end else if (global_flush) begin
      mq.delete();
      e_cv = 0; e_fv = 0;
    end else begin
      can_alloc = (mq.size() < DEPTH);
      ret = (mq.size() > 0) && mq[0].done && !commit_stall;
      if (ret) r = mq[0];
      if (wb_done) begin
        k = (int'(wb_index) - (m_head % DEPTH) + DEPTH) % DEPTH;
        if (k < mq.size()) mq[k].done = 1'b1;
      end
      if (ret) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % (2 * DEPTH);
        e_cv = 1; e_fv = r.hd; e_cva = r.v; e_cpa = r.p; e_fpa = r.old;
      end else begin
        e_cv = 0; e_fv = 0;
      end
      if (alloc_valid && can_alloc) begin
        r.v = int'(alloc_vaddr); r.p = int'(alloc_paddr); r.old = int'(alloc_old);
        r.hd = alloc_has_dest; r.done = 1'b0;
        mq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); cycle(); cycle(); rst = 1'b0; cycle();
    vectors++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %0b exp 1", empty); end
    vectors++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
    vectors++; if (alloc_index !== 3'd0) begin errs++; $display("FAIL reset_alloc_index got %0d exp 0", alloc_index); end
    vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL reset_commit_valid got %0b exp 0", commit_valid); end
    vectors++; if (free_valid !== 1'b0) begin errs++; $display("FAIL reset_free_valid got %0b exp 0", free_valid); end
  endtask

  task automatic test_commit_in_order();
    do_reset();
    set_alloc(1, 1, 33, 1); cycle();
    set_alloc(1, 2, 34, 2); cycle();
    set_alloc(1, 3, 35, 3); cycle();
    idle();
    vectors++; if (count !== 4'd3) begin errs++; $display("FAIL basic_count3 got %0d exp 3", count); end
    vectors++; if (alloc_index !== 3'd3) begin errs++; $display("FAIL basic_alloc_index got %0d exp 3", alloc_index); end
    set_wb(0); cycle(); wb_done = 1'b0;
    vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL latency_n1 commit_valid got %0b exp 0", commit_valid); end
    cycle();
    vectors++; if (commit_valid !== 1'b1) begin errs++; $display("FAIL latency_n2 commit_valid got %0b exp 1", commit_valid); end
    vectors++; if (commit_vaddr !== 5'd1) begin errs++; $display("FAIL basic_vaddr got %0d exp 1", commit_vaddr); end
    vectors++; if (commit_paddr !== 6'd33) begin errs++; $display("FAIL basic_paddr got %0d exp 33", commit_paddr); end
    vectors++; if (free_valid !== 1'b1 || free_paddr !== 6'd1) begin errs++; $display("FAIL basic_free got %0b/%0d exp 1/1", free_valid, free_paddr); end
    vectors++; if (count !== 4'd2) begin errs++; $display("FAIL basic_count2 got %0d exp 2", count); end
    // out-of-order completion: index 2 then index 1
    set_wb(2); cycle();
    vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL ooo_hold1 commit_valid got %0b exp 0", commit_valid); end
    set_wb(1); cycle(); wb_done = 1'b0;
    vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL ooo_hold2 commit_valid got %0b exp 0", commit_valid); end
    cycle();
    vectors++; if (commit_valid !== 1'b1 || commit_paddr !== 6'd34 || free_paddr !== 6'd2) begin errs++; $display("FAIL ooo_first got %0b/%0d/%0d exp 1/34/2", commit_valid, commit_paddr, free_paddr); end
    cycle();
    vectors++; if (commit_valid !== 1'b1 || commit_paddr !== 6'd35 || free_paddr !== 6'd3) begin errs++; $display("FAIL ooo_second got %0b/%0d/%0d exp 1/35/3", commit_valid, commit_paddr, free_paddr); end
    cycle();
    vectors++; if (commit_valid !== 1'b0 || empty !== 1'b1 || commit_paddr !== 6'd35) begin errs++; $display("FAIL ooo_drained got %0b/%0b/%0d exp 0/1/35", commit_valid, empty, commit_paddr); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1, i + 8, i + 40, i + 16); cycle();
    end
    vectors++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin errs++; $display("FAIL full_ready got %0b/%0d exp 0/8", alloc_ready, count); end
    set_alloc(1, 31, 63, 30); cycle(); idle();
    vectors++; if (count !== 4'd8 || alloc_index !== 3'd0) begin errs++; $display("FAIL full_ignored got %0d/%0d exp 8/0", count, alloc_index); end
    set_wb(0); cycle(); wb_done = 1'b0;
    vectors++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin errs++; $display("FAIL full_retire_cycle got %0b/%0b exp 0/0", alloc_ready, commit_valid); end
    cycle();
    vectors++; if (alloc_ready !== 1'b1 || commit_valid !== 1'b1 || commit_paddr !== 6'd40 || count !== 4'd7) begin errs++; $display("FAIL full_after_retire got %0b/%0b/%0d/%0d exp 1/1/40/7", alloc_ready, commit_valid, commit_paddr, count); end
    vectors++; if (alloc_index !== 3'd0) begin errs++; $display("FAIL wrap_index got %0d exp 0", alloc_index); end
    set_alloc(1, 21, 61, 5); cycle(); idle();
    vectors++; if (count !== 4'd8 || alloc_index !== 3'd1 || dut.tail_q !== 4'd9) begin errs++; $display("FAIL wrap_tail got %0d/%0d/%0d exp 8/1/9", count, alloc_index, dut.tail_q); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(1, i + 1, i + 20, i + 10); cycle();
    end
    idle();
    set_wb(1); cycle(); set_wb(2); cycle(); idle();
    vectors++; if (count !== 4'd5) begin errs++; $display("FAIL flush_pre_count got %0d exp 5", count); end
    global_flush = 1'b1; set_alloc(1, 30, 60, 7); set_wb(0); cycle(); idle();
    vectors++; if (count !== 4'd0 || empty !== 1'b1) begin errs++; $display("FAIL flush_count got %0d/%0b exp 0/1", count, empty); end
    vectors++; if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin errs++; $display("FAIL flush_outputs got %0b/%0b exp 0/0", commit_valid, free_valid); end
    vectors++; if (alloc_index !== 3'd0) begin errs++; $display("FAIL flush_alloc_index got %0d exp 0", alloc_index); end
    cycle();
    vectors++; if (commit_valid !== 1'b0 || count !== 4'd0) begin errs++; $display("FAIL flush_dropped got %0b/%0d exp 0/0", commit_valid, count); end
    set_alloc(1, 4, 44, 14); cycle();
    set_alloc(1, 5, 45, 15); cycle(); idle();
    set_wb(0); cycle(); idle(); cycle();
    vectors++; if (commit_valid !== 1'b1 || commit_paddr !== 6'd44) begin errs++; $display("FAIL flush_reuse got %0b/%0d exp 1/44", commit_valid, commit_paddr); end
    cycle();
    vectors++; if (commit_valid !== 1'b0 || count !== 4'd1) begin errs++; $display("FAIL flush_stale_done got %0b/%0d exp 0/1", commit_valid, count); end
  endtask

  task automatic test_nodest_stall();
    do_reset();
    set_alloc(0, 9, 50, 12); cycle(); idle();
    commit_stall = 1'b1; set_wb(0); cycle(); wb_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL stall_hold%0d got %0b exp 0", i, commit_valid); end
      cycle();
    end
    vectors++; if (commit_valid !== 1'b0) begin errs++; $display("FAIL stall_hold2 got %0b exp 0", commit_valid); end
    commit_stall = 1'b0; cycle();
    vectors++; if (commit_valid !== 1'b1 || free_valid !== 1'b0) begin errs++; $display("FAIL nodest_valid got %0b/%0b exp 1/0", commit_valid, free_valid); end
    vectors++; if (commit_vaddr !== 5'd9 || commit_paddr !== 6'd50 || free_paddr !== 6'd12) begin errs++; $display("FAIL nodest_addr got %0d/%0d/%0d exp 9/50/12", commit_vaddr, commit_paddr, free_paddr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_alloc(1, 6, 36, 26); cycle();
    set_alloc(1, 7, 37, 27); cycle(); idle();
    set_wb(0); cycle();
    set_alloc(1, 8, 38, 28); set_wb(1); cycle(); idle();
    vectors++; if (commit_valid !== 1'b1 || commit_paddr !== 6'd36 || count !== 4'd2) begin errs++; $display("FAIL b2b_first got %0b/%0d/%0d exp 1/36/2", commit_valid, commit_paddr, count); end
    cycle();
    vectors++; if (commit_valid !== 1'b1 || commit_paddr !== 6'd37 || count !== 4'd1) begin errs++; $display("FAIL b2b_second got %0b/%0d/%0d exp 1/37/1", commit_valid, commit_paddr, count); end
    // reset while a retire is pending: no commit or free pulse
    set_wb(2); cycle(); idle();
    rst = 1'b1; cycle(); rst = 1'b0;
    vectors++; if (commit_valid !== 1'b0 || free_valid !== 1'b0 || count !== 4'd0) begin errs++; $display("FAIL midop_reset got %0b/%0b/%0d exp 0/0/0", commit_valid, free_valid, count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      global_flush = ($urandom_range(0, 39) == 0);
      commit_stall = ($urandom_range(0, 3) == 0);
      alloc_valid  = ($urandom_range(0, 2) != 0);
      alloc_has_dest = ($urandom_range(0, 3) != 0);
      alloc_vaddr  = VW'($urandom);
      alloc_paddr  = PW'($urandom);
      alloc_old    = PW'($urandom);
      wb_done      = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_index = FLW'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
      else
        wb_index = FLW'($urandom);
      cycle();
      vectors++; if (count !== (FLW+1)'(mq.size())) begin errs++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, mq.size()); end
      vectors++; if (empty !== (mq.size() == 0)) begin errs++; $display("FAIL rnd_empty cyc %0d got %0b", c, empty); end
      vectors++; if (alloc_ready !== (mq.size() < DEPTH)) begin errs++; $display("FAIL rnd_alloc_ready cyc %0d got %0b", c, alloc_ready); end
      vectors++; if (alloc_index !== FLW'((m_head + mq.size()) % DEPTH)) begin errs++; $display("FAIL rnd_alloc_index cyc %0d got %0d exp %0d", c, alloc_index, (m_head + mq.size()) % DEPTH); end
      vectors++; if (commit_valid !== e_cv) begin errs++; $display("FAIL rnd_commit_valid cyc %0d got %0b exp %0b", c, commit_valid, e_cv); end
      vectors++; if (free_valid !== e_fv) begin errs++; $display("FAIL rnd_free_valid cyc %0d got %0b exp %0b", c, free_valid, e_fv); end
      vectors++; if (commit_vaddr !== VW'(e_cva)) begin errs++; $display("FAIL rnd_commit_vaddr cyc %0d got %0d exp %0d", c, commit_vaddr, e_cva); end
      vectors++; if (commit_paddr !== PW'(e_cpa)) begin errs++; $display("FAIL rnd_commit_paddr cyc %0d got %0d exp %0d", c, commit_paddr, e_cpa); end
      vectors++; if (free_paddr !== PW'(e_fpa)) begin errs++; $display("FAIL rnd_free_paddr cyc %0d got %0d exp %0d", c, free_paddr, e_fpa); end
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1; idle();
    alloc_has_dest = 1'b0; alloc_vaddr = '0; alloc_paddr = '0; alloc_old = '0; wb_index = '0;
    m_head = 0;
    test_reset();
    test_commit_in_order();
    test_full_wrap();
    test_flush();
    test_nodest_stall();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
